// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: GPR and HI/LO write bundle behind a
// valid/ready handshake with a 2-entry skid buffer and retire counter.
module mem_wb_stage #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int ZERO_SUPPRESS = 1,
    parameter int RETIRE_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_wreg_addr,
    input  logic [DATA_W-1:0]   in_wreg_data,
    input  logic                in_wreg_en,
    input  logic [DATA_W-1:0]   in_hi,
    input  logic [DATA_W-1:0]   in_lo,
    input  logic                in_hilo_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_wreg_addr,
    output logic [DATA_W-1:0]   out_wreg_data,
    output logic                out_wreg_en,
    output logic [DATA_W-1:0]   out_hi,
    output logic [DATA_W-1:0]   out_lo,
    output logic                out_hilo_en,
    output logic [RETIRE_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wreg_en;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              hilo_en;
    } beat_t;

    state_t state;
    state_t state_nx;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  cap;
    logic   in_fire;
    logic   out_fire;
    logic   main_ld_in;
    logic   main_ld_skid;
    logic   skid_ld;
    logic   zero_dst;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Writes to $zero are architecturally dead; drop the enable at capture.
    assign zero_dst = (ZERO_SUPPRESS != 0) && (in_wreg_addr == '0);

    always_comb begin
        cap.addr    = in_wreg_addr;
        cap.data    = in_wreg_data;
        cap.wreg_en = in_wreg_en & ~zero_dst;
        cap.hi      = in_hi;
        cap.lo      = in_lo;
        cap.hilo_en = in_hilo_en;
    end

    always_comb begin
        state_nx     = state;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ld_in = 1'b1;
                        state_nx   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld_in = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                    end else if (in_fire) begin
                        skid_ld  = 1'b1;
                        state_nx = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ld_skid = 1'b1;
                        state_nx     = ONE;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            retire_cnt <= '0;
        end else begin
            state <= state_nx;
            if (main_ld_in) begin
                main_q <= cap;
            end else if (main_ld_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= cap;
            end
            if (out_fire) begin
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
        end
    end

    assign out_wreg_addr = main_q.addr;
    assign out_wreg_data = main_q.data;
    assign out_hi        = main_q.hi;
    assign out_lo        = main_q.lo;
    assign out_wreg_en   = main_q.wreg_en & out_valid;
    assign out_hilo_en   = main_q.hilo_en & out_valid;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: handshake, skid, flush,
// zero suppression, async reset and retire counter wrap.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_wreg_addr;
    logic [31:0] in_wreg_data;
    logic        in_wreg_en;
    logic [31:0] in_hi;
    logic [31:0] in_lo;
    logic        in_hilo_en;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_wreg_addr;
    logic [31:0] out_wreg_data;
    logic        out_wreg_en;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        out_hilo_en;
    logic [31:0] retire_cnt;

    logic        n_in_ready;
    logic        n_out_valid;
    logic [4:0]  n_wreg_addr;
    logic [31:0] n_wreg_data;
    logic        n_wreg_en;
    logic [31:0] n_hi;
    logic [31:0] n_lo;
    logic        n_hilo_en;
    logic [3:0]  n_retire_cnt;

    int compared = 0;
    int mismatched = 0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wreg_addr(in_wreg_addr), .in_wreg_data(in_wreg_data),
        .in_wreg_en(in_wreg_en), .in_hi(in_hi), .in_lo(in_lo),
        .in_hilo_en(in_hilo_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wreg_addr(out_wreg_addr), .out_wreg_data(out_wreg_data),
        .out_wreg_en(out_wreg_en), .out_hi(out_hi), .out_lo(out_lo),
        .out_hilo_en(out_hilo_en), .retire_cnt(retire_cnt)
    );

    mem_wb_stage #(.RETIRE_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_wreg_addr(in_wreg_addr), .in_wreg_data(in_wreg_data),
        .in_wreg_en(in_wreg_en), .in_hi(in_hi), .in_lo(in_lo),
        .in_hilo_en(in_hilo_en),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_wreg_addr(n_wreg_addr), .out_wreg_data(n_wreg_data),
        .out_wreg_en(n_wreg_en), .out_hi(n_hi), .out_lo(n_lo),
        .out_hilo_en(n_hilo_en), .retire_cnt(n_retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a,
                         input logic [31:0] d);
        in_valid     = v;
        in_wreg_addr = a;
        in_wreg_data = d;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        in_wreg_en = 1'b1;
        in_hi = '0;
        in_lo = '0;
        in_hilo_en = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", 64'(out_wreg_data), 64'd0);
        chk("rst_wreg_en", 64'(out_wreg_en), 64'd0);
        chk("rst_retire", 64'(retire_cnt), 64'd0);
        step();
        rst = 1'b0;

        // single beat, latency 1
        out_ready = 1'b1;
        drive(1'b1, 5'd5, 32'h1234_5678);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("one_valid", 64'(out_valid), 64'd1);
        chk("one_addr", 64'(out_wreg_addr), 64'd5);
        chk("one_data", 64'(out_wreg_data), 64'h1234_5678);
        chk("one_wreg_en", 64'(out_wreg_en), 64'd1);
        step();
        chk("one_retire", 64'(retire_cnt), 64'd1);
        chk("one_drained", 64'(out_valid), 64'd0);

        // backpressure into FULL
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 32'hA);
        step();
        drive(1'b1, 5'd2, 32'hB);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_data_a", 64'(out_wreg_data), 64'hA);
        step();
        chk("bp_hold_a", 64'(out_wreg_data), 64'hA);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_data_b", 64'(out_wreg_data), 64'hB);
        chk("bp_addr_b", 64'(out_wreg_addr), 64'd2);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);
        chk("bp_retire", 64'(retire_cnt), 64'd3);

        // streaming at full rate
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 5'd7, 32'(i));
            chk("st_in_ready", 64'(in_ready), 64'd1);
            step();
            chk("st_data", 64'(out_wreg_data), 64'(i));
        end
        drive(1'b0, 5'd0, 32'd0);
        step();
        chk("st_retire", 64'(retire_cnt), 64'd103);

        // $zero destination
        out_ready = 1'b0;
        in_hilo_en = 1'b1;
        in_hi = 32'hFFFF_0000;
        in_lo = 32'h0000_FFFF;
        drive(1'b1, 5'd0, 32'h55);
        step();
        drive(1'b0, 5'd0, 32'd0);
        in_hilo_en = 1'b0;
        chk("zs_wreg_en", 64'(out_wreg_en), 64'd0);
        chk("zs_hilo_en", 64'(out_hilo_en), 64'd1);
        chk("zs_hi", 64'(out_hi), 64'hFFFF_0000);
        chk("zs_lo", 64'(out_lo), 64'h0000_FFFF);
        out_ready = 1'b1;
        step();
        chk("zs_retire", 64'(retire_cnt), 64'd104);

        // flush while FULL with a concurrent input
        out_ready = 1'b0;
        drive(1'b1, 5'd3, 32'hC);
        step();
        drive(1'b1, 5'd4, 32'hD);
        step();
        drive(1'b1, 5'd6, 32'hE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_wreg_en", 64'(out_wreg_en), 64'd0);
        chk("fl_payload_kept", 64'(out_wreg_data), 64'hC);
        out_ready = 1'b1;
        step();
        chk("fl_stays_empty", 64'(out_valid), 64'd0);
        chk("fl_retire", 64'(retire_cnt), 64'd104);

        // flush with an output handshake still retires it
        drive(1'b1, 5'd8, 32'hF);
        step();
        drive(1'b0, 5'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flr_valid", 64'(out_valid), 64'd0);
        chk("flr_retire", 64'(retire_cnt), 64'd105);

        // async reset in the middle of a cycle while FULL
        out_ready = 1'b0;
        drive(1'b1, 5'd9, 32'h1111);
        step();
        drive(1'b1, 5'd10, 32'h2222);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("ar_pre_full", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_data", 64'(out_wreg_data), 64'd0);
        chk("ar_addr", 64'(out_wreg_addr), 64'd0);
        chk("ar_wreg_en", 64'(out_wreg_en), 64'd0);
        chk("ar_retire", 64'(retire_cnt), 64'd0);
        step();
        rst = 1'b0;

        // 17 handshakes: narrow counter wraps to 1
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 5'd11, 32'(100 + i));
            step();
            chk("wr_data", 64'(out_wreg_data), 64'(100 + i));
        end
        drive(1'b0, 5'd0, 32'd0);
        step();
        chk("wr_retire32", 64'(retire_cnt), 64'd17);
        chk("wr_retire4", 64'(n_retire_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
